// File: rtl/mod_alu_arb_if.sv
// rtl/mod_alu_arb_if.sv - requester and mod_alu bundle for the shared-ALU arbiter
interface mod_alu_arb_if #(
    parameter int N = 8,
    parameter int R = 4
);
    // each sd2_t digit occupies two bits
    logic [R-1:0]             req;
    logic [R-1:0]             req_mode;
    logic [R-1:0][2*N-1:0]    req_m;
    logic [R-1:0][2*N-1:0]    req_x;
    logic [R-1:0][2*N-1:0]    req_y;
    logic [R-1:0]             gnt;
    logic [R-1:0]             rsp_valid;
    logic [2*N-1:0]           rsp_z;
    logic                     rsp_err;
    logic                     busy;
    logic                     alu_rst;
    logic                     alu_start;
    logic                     alu_mode;
    logic [2*N-1:0]           alu_m;
    logic [2*N-1:0]           alu_x;
    logic [2*N-1:0]           alu_y;
    logic                     alu_done;
    logic [2*N-1:0]           alu_z;

    modport master (
        output req, req_mode, req_m, req_x, req_y, alu_done, alu_z,
        input  gnt, rsp_valid, rsp_z, rsp_err, busy,
        input  alu_rst, alu_start, alu_mode, alu_m, alu_x, alu_y
    );

    modport slave (
        input  req, req_mode, req_m, req_x, req_y, alu_done, alu_z,
        output gnt, rsp_valid, rsp_z, rsp_err, busy,
        output alu_rst, alu_start, alu_mode, alu_m, alu_x, alu_y
    );
endinterface

// File: rtl/mod_alu_arb.sv
// rtl/mod_alu_arb.sv - round-robin arbiter sharing one mod_alu among R requesters
// Optional WAIT-state watchdog is compiled in with MOD_ALU_ARB_TIMEOUT_EN.
module mod_alu_arb #(
    parameter int N         = 8,
    parameter int R         = 4,
    parameter int TO_CYCLES = 4 * N + 16
) (
    input  logic         clk,
    input  logic         rst,
    mod_alu_arb_if.slave bus
);
    localparam int W  = 2 * N;
    localparam int OW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d, last_owner_q, last_owner_d;
    logic [OW-1:0]   pick, idx;
    logic            found;
    logic            mode_q, mode_d;
    logic [W-1:0]    m_q, m_d, x_q, x_d, y_q, y_d, rsp_z_q, rsp_z_d;
    logic [R-1:0]    gnt_c, rsp_valid_q, rsp_valid_d;
    logic            busy_q, busy_d, alu_start_q, alu_start_d;

`ifdef MOD_ALU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES + 1);
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rsp_err_q, rsp_err_d;
    logic            wd_fire;

    // done arriving on the final watchdog cycle still wins over the abort
    assign wd_fire = (state_q == WAIT) && !bus.alu_done && (cnt_q == CW'(TO_CYCLES - 1));
`else
    logic            unused_to;
    assign unused_to = (TO_CYCLES > 0);
`endif

    // first requesting index after the last owner, wrapping around
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 1; i <= R; i++) begin
            idx = OW'((int'(last_owner_q) + i) % R);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        mode_d       = mode_q;
        m_d          = m_q;
        x_d          = x_q;
        y_d          = y_q;
        rsp_z_d      = rsp_z_q;
        gnt_c        = '0;
`ifdef MOD_ALU_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        rsp_err_d    = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (found && !rst) begin
                    gnt_c[pick] = 1'b1;
                    owner_d     = pick;
                    mode_d      = bus.req_mode[pick];
                    m_d         = bus.req_m[pick];
                    x_d         = bus.req_x[pick];
                    y_d         = bus.req_y[pick];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef MOD_ALU_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (bus.alu_done) begin
                    rsp_z_d   = bus.alu_z;
`ifdef MOD_ALU_ARB_TIMEOUT_EN
                    rsp_err_d = 1'b0;
`endif
                    state_d   = RESP;
                end
`ifdef MOD_ALU_ARB_TIMEOUT_EN
                else if (wd_fire) begin
                    rsp_z_d   = '0;
                    rsp_err_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            RESP: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d              = (state_d != IDLE);
        alu_start_d         = (state_d == ISSUE);
        rsp_valid_d         = '0;
        if (state_d == RESP) begin
            rsp_valid_d[owner_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= OW'(R - 1);
            mode_q       <= 1'b0;
            m_q          <= '0;
            x_q          <= '0;
            y_q          <= '0;
            rsp_z_q      <= '0;
            rsp_valid_q  <= '0;
            busy_q       <= 1'b0;
            alu_start_q  <= 1'b0;
`ifdef MOD_ALU_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            mode_q       <= mode_d;
            m_q          <= m_d;
            x_q          <= x_d;
            y_q          <= y_d;
            rsp_z_q      <= rsp_z_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
            alu_start_q  <= alu_start_d;
`ifdef MOD_ALU_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_z     = rsp_z_q;
    assign bus.busy      = busy_q;
    assign bus.alu_start = alu_start_q;
    assign bus.alu_mode  = mode_q;
    assign bus.alu_m     = m_q;
    assign bus.alu_x     = x_q;
    assign bus.alu_y     = y_q;
`ifdef MOD_ALU_ARB_TIMEOUT_EN
    assign bus.alu_rst   = rst | wd_fire;
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.alu_rst   = rst;
    assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_mod_alu_arb.sv
// tb/tb_mod_alu_arb.sv - randomized self-checking bench for mod_alu_arb
module tb_mod_alu_arb;
    localparam int N  = 8;
    localparam int R  = 4;
    localparam int TO = 20;
    localparam int W  = 2 * N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mod_alu_arb_if #(.N(N), .R(R)) bus ();
    mod_alu_arb #(.N(N), .R(R), .TO_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int nchk  = 0;
    int npass = 0;
    int last_owner;
    logic [W-1:0] sv_m, sv_x, sv_y;
    logic         sv_mode;
    logic [W-1:0] last_z;

    // stand-in for mod_alu: any fixed function of the operands will do
    function automatic logic [W-1:0] alu_f(input logic [W-1:0] m, x, y, input logic md);
        return md ? ((x + y) ^ m) : ~((x - y) ^ m);
    endfunction

    function automatic int rr_pick(input logic [R-1:0] r, input int last);
        for (int i = 1; i <= R; i++) begin
            if (r[(last + i) % R]) return (last + i) % R;
        end
        return -1;
    endfunction

    function automatic logic [R-1:0] onehot(input int i);
        logic [R-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < R; i++) begin
            bus.req_m[i]    = W'($urandom);
            bus.req_x[i]    = W'($urandom);
            bus.req_y[i]    = W'($urandom);
            bus.req_mode[i] = 1'($urandom_range(0, 1));
        end
    endtask

    // one full transaction starting at an IDLE negedge with req already driven
    task automatic txn(input int lat, input bit mutate, input bit drop);
        int own;
        logic [W-1:0] exp_z;
        #1;
        own = rr_pick(bus.req, last_owner);
        check("gnt", 64'(bus.gnt), 64'(onehot(own)));
        check("busy_idle", 64'(bus.busy), 64'(0));
        sv_m = bus.req_m[own]; sv_x = bus.req_x[own]; sv_y = bus.req_y[own]; sv_mode = bus.req_mode[own];
        exp_z = alu_f(sv_m, sv_x, sv_y, sv_mode);
        @(negedge clk);
        check("alu_start_issue", 64'(bus.alu_start), 64'(1));
        check("gnt_busy", 64'(bus.gnt), 64'(0));
        check("busy", 64'(bus.busy), 64'(1));
        check("alu_ops", {bus.alu_m, bus.alu_x, bus.alu_y, 15'(0), bus.alu_mode}, {sv_m, sv_x, sv_y, 15'(0), sv_mode});
        @(negedge clk);
        check("alu_start_wait", 64'(bus.alu_start), 64'(0));
        if (mutate) begin
            bus.req_x[own] = ~bus.req_x[own];
            bus.req_m[own] = bus.req_m[own] + 1'b1;
        end
        for (int k = 0; k < lat; k++) begin
            #1;
            check("rsp_valid_wait", 64'(bus.rsp_valid), 64'(0));
            check("alu_x_hold", 64'(bus.alu_x), 64'(sv_x));
            @(negedge clk);
        end
        bus.alu_done = 1'b1;
        bus.alu_z    = alu_f(bus.alu_m, bus.alu_x, bus.alu_y, bus.alu_mode);
        @(negedge clk);
        bus.alu_done = 1'b0;
        check("rsp_valid", 64'(bus.rsp_valid), 64'(onehot(own)));
        check("rsp_z", 64'(bus.rsp_z), 64'(exp_z));
        check("rsp_err", 64'(bus.rsp_err), 64'(0));
        check("alu_rst_norm", 64'(bus.alu_rst), 64'(0));
        last_owner = own;
        last_z     = exp_z;
        if (drop) bus.req[own] = 1'b0;
        @(negedge clk);
        check("rsp_valid_pulse", 64'(bus.rsp_valid), 64'(0));
        check("rsp_z_hold", 64'(bus.rsp_z), 64'(last_z));
    endtask

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        bus.req = '1;
        bus.alu_done = 1'b0;
        bus.alu_z = '0;
        randomize_ops();
        repeat (3) @(negedge clk);
        #1;
        check("rst_gnt", 64'(bus.gnt), 64'(0));
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_alu_start", 64'(bus.alu_start), 64'(0));
        check("rst_rsp_z", 64'(bus.rsp_z), 64'(0));
        check("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
        check("rst_alu_rst", 64'(bus.alu_rst), 64'(1));
        bus.req = '0;
        rst = 1'b0;
        last_owner = R - 1;
        @(negedge clk);
        #1;
        check("alu_rst_low", 64'(bus.alu_rst), 64'(0));
        check("gnt_noreq", 64'(bus.gnt), 64'(0));

        // single requester 0, mode 0
        bus.req_mode[0] = 1'b0;
        bus.req_x[0] = W'(5); bus.req_y[0] = W'(3); bus.req_m[0] = W'(11);
        bus.req = 4'b0001;
        txn(0, 1'b0, 1'b1);

        // all requesters held from reset: order 0,1,2,3,0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_owner = R - 1;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_order", 64'(bus.gnt), 64'(onehot(order[k])));
            txn(k % 3, 1'b0, 1'b0);
        end

        // random request patterns, operands and ALU latency
        for (int k = 0; k < 24; k++) begin
            randomize_ops();
            bus.req = bus.req | 4'($urandom_range(0, 15));
            if (bus.req == '0) bus.req = 4'b1000;
            txn(int'($urandom_range(0, 4)), 1'b0, 1'($urandom_range(0, 1)));
        end

        // operands changed after grant must not matter
        bus.req = 4'b0100;
        txn(3, 1'b1, 1'b1);

        // reset during WAIT abandons the operation
        bus.req = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("abort_gnt", 64'(bus.gnt), 64'(0));
        rst = 1'b0;
        bus.req = 4'b1111;
        last_owner = R - 1;
        #1;
        check("abort_next_gnt", 64'(bus.gnt), 64'(1));
        txn(1, 1'b0, 1'b0);

`ifdef MOD_ALU_ARB_TIMEOUT_EN
        begin
            int own;
            logic [W-1:0] exp_z;
            bus.req = 4'b0001;
            #1;
            own = rr_pick(bus.req, last_owner);
            @(negedge clk);
            @(negedge clk);
            for (int k = 1; k <= TO; k++) begin
                #1;
                check("wd_alu_rst", 64'(bus.alu_rst), 64'(k == TO));
                if (k < TO) @(negedge clk);
            end
            @(negedge clk);
            check("wd_rsp_valid", 64'(bus.rsp_valid), 64'(onehot(own)));
            check("wd_rsp_err", 64'(bus.rsp_err), 64'(1));
            check("wd_rsp_z", 64'(bus.rsp_z), 64'(0));
            last_owner = own;
            @(negedge clk);

            #1;
            own = rr_pick(bus.req, last_owner);
            exp_z = alu_f(bus.req_m[own], bus.req_x[own], bus.req_y[own], bus.req_mode[own]);
            @(negedge clk);
            @(negedge clk);
            for (int k = 1; k < TO; k++) @(negedge clk);
            bus.alu_done = 1'b1;
            bus.alu_z = alu_f(bus.alu_m, bus.alu_x, bus.alu_y, bus.alu_mode);
            #1;
            check("wd_race_alu_rst", 64'(bus.alu_rst), 64'(0));
            @(negedge clk);
            bus.alu_done = 1'b0;
            check("wd_race_rsp_err", 64'(bus.rsp_err), 64'(0));
            check("wd_race_rsp_z", 64'(bus.rsp_z), 64'(exp_z));
            check("wd_race_rsp_valid", 64'(bus.rsp_valid), 64'(onehot(own)));
            last_owner = own;
            bus.req = '0;
            @(negedge clk);
        end
`endif

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
